irq_cond: RTL

Interrupt pin conditioner sitting directly upstream of `pimc`. It takes raw asynchronous platform IRQ pins and synchronises, de-glitches and polarity-corrects them. Each line is then classified as level- or edge-triggered and presented to `pimc` as a clean, registered, active-high `irq_out` vector. Edge-triggered lines stay latched until software issues an end-of-interrupt (EOI) for that line, so short pulses are never lost while `pimc` is busy.

---
 rtl/irq_cond.sv | 114 +++++++++++
 1 files changed

// File: rtl/irq_cond.sv
// Interrupt pin conditioner: synchronises, de-glitches and polarity-corrects raw IRQ pins,
// then presents level or latched-edge requests to pimc as a registered active-high vector.
module irq_cond #(
  parameter int IRQ_PIN_COUNT = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IRQ_PIN_COUNT-1:0] pin_in,
  input  logic                     cfg_we,
  input  logic [7:0]               cfg_line,
  input  logic [2:0]               cfg_data,
  input  logic                     eoi,
  input  logic [7:0]               eoi_line,
  output logic [IRQ_PIN_COUNT-1:0] irq_out,
  output logic [IRQ_PIN_COUNT-1:0] overflow
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [IRQ_PIN_COUNT-1:0] sync_q [SYNC_STAGES];
  logic [IRQ_PIN_COUNT-1:0] sync_lvl;
  logic [IRQ_PIN_COUNT-1:0] filt;
  logic [CW-1:0]            cnt [IRQ_PIN_COUNT];
  logic [IRQ_PIN_COUNT-1:0] trig;
  logic [IRQ_PIN_COUNT-1:0] pol;
  logic [IRQ_PIN_COUNT-1:0] en;
  logic [IRQ_PIN_COUNT-1:0] prev;
  logic [IRQ_PIN_COUNT-1:0] pending;
  logic [IRQ_PIN_COUNT-1:0] asrt;
  logic [IRQ_PIN_COUNT-1:0] set_term;
  logic [IRQ_PIN_COUNT-1:0] cfg_hit;
  logic [IRQ_PIN_COUNT-1:0] eoi_hit;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign asrt     = filt ^ pol;
  assign set_term = asrt & ~prev & en;
  assign irq_out  = pending;

  // Exact 8-bit compare against each line index: indices >= IRQ_PIN_COUNT match nothing.
  always_comb begin
    cfg_hit = '0;
    eoi_hit = '0;
    for (int unsigned i = 0; i < IRQ_PIN_COUNT; i++) begin
      cfg_hit[i] = cfg_we && (cfg_line == 8'(i));
      eoi_hit[i] = eoi && (eoi_line == 8'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // The sample that would make the count reach FILTER_CYCLES commits the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      for (int unsigned i = 0; i < IRQ_PIN_COUNT; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < IRQ_PIN_COUNT; i++) begin
        if (sync_lvl[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_CYCLES - 1)) begin
          filt[i] <= sync_lvl[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig     <= '0;
      pol      <= '0;
      en       <= '0;
      prev     <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      for (int unsigned i = 0; i < IRQ_PIN_COUNT; i++) begin
        if (cfg_hit[i]) begin
          // Seed history with the new polarity so a reconfigure never looks like an edge.
          trig[i]     <= cfg_data[0];
          pol[i]      <= cfg_data[1];
          en[i]       <= cfg_data[2];
          prev[i]     <= filt[i] ^ cfg_data[1];
          pending[i]  <= 1'b0;
          overflow[i] <= 1'b0;
        end else begin
          prev[i] <= asrt[i];
          if (!trig[i]) begin
            pending[i] <= asrt[i] & en[i];
          end else if (set_term[i]) begin
            pending[i] <= 1'b1;
            if (eoi_hit[i])      overflow[i] <= 1'b0;
            else if (pending[i]) overflow[i] <= 1'b1;
          end else if (eoi_hit[i]) begin
            pending[i]  <= 1'b0;
            overflow[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
